// File: rtl/rv_prefetch_buf.sv
// Instruction prefetch buffer: issues in-order req/gnt/rvalid fetches into a DEPTH-entry FIFO
// that the core drains with valid/ready; a redirect flushes the FIFO and discards in-flight data.
module rv_prefetch_buf #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] flush_addr_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_ready_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW:0] CreditMax = (CntW + 1)'(DEPTH);

    typedef logic [CntW-1:0] cnt_t;
    typedef logic [PtrW-1:0] ptr_t;

    cnt_t                  count_q, count_d;
    cnt_t                  outst_q, outst_d;
    cnt_t                  drop_q, drop_d;
    ptr_t                  wptr_q, wptr_d;
    ptr_t                  rptr_q, rptr_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic                  req_en_q;

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] tag_q  [DEPTH];

    logic        grant;
    logic        rsp;
    logic        drop;
    logic        push;
    logic        pop;
    logic [CntW:0] credits_used;

    // Every granted request reserves a FIFO slot, so pushes can never overflow.
    always_comb begin
        credits_used = {1'b0, count_q} + {1'b0, outst_q};
        mem_req_o    = req_en_q && !flush_i && (credits_used < CreditMax);
        mem_addr_o   = fetch_pc_q;

        instr_valid_o = (count_q != '0) && !flush_i;
        instr_o       = data_q[rptr_q];
        instr_addr_o  = tag_q[rptr_q];

        grant = mem_req_o && mem_gnt_i;
        // Responses with nothing outstanding are stray (e.g. across a reset) and are ignored.
        rsp   = mem_rvalid_i && (outst_q != '0);
        drop  = rsp && (flush_i || (drop_q != '0));
        push  = rsp && !drop;
        pop   = instr_valid_o && instr_ready_i;
    end

    always_comb begin
        count_d    = count_q;
        outst_d    = outst_q + cnt_t'(grant) - cnt_t'(rsp);
        drop_d     = drop_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;

        if (flush_i) begin
            count_d    = '0;
            wptr_d     = rptr_q;
            // Whatever is still in flight after this cycle predates the redirect.
            drop_d     = outst_q - cnt_t'(rsp);
            fetch_pc_d = flush_addr_i;
            resp_pc_d  = flush_addr_i;
        end else begin
            count_d    = count_q + cnt_t'(push) - cnt_t'(pop);
            wptr_d     = wptr_q + ptr_t'(push);
            rptr_d     = rptr_q + ptr_t'(pop);
            drop_d     = drop_q - cnt_t'(drop);
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(grant);
            resp_pc_d  = resp_pc_q + ADDR_WIDTH'(push);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fetch_pc_q <= RESET_ADDR;
            resp_pc_q  <= RESET_ADDR;
            req_en_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            req_en_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= RESET_ADDR;
            end
        end else if (push) begin
            data_q[wptr_q] <= mem_rdata_i;
            tag_q[wptr_q]  <= resp_pc_q;
        end
    end

`ifndef SYNTHESIS
    logic seen_gnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seen_gnt_q <= 1'b0;
        end else if (grant) begin
            seen_gnt_q <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rstn) begin
            assert (!(mem_rvalid_i && (outst_q == '0) && seen_gnt_q));
            assert (credits_used <= CreditMax);
        end
    end
`endif

endmodule

// File: tb/tb_rv_prefetch_buf.sv
// Scoreboard bench for rv_prefetch_buf: a queue-based memory model answers grants in order, and the
// expected stream after each reset/redirect is "start, start+1, ..." with word = 0x1000_0000 + addr.
module tb_rv_prefetch_buf;

    localparam int unsigned    DW       = 32;
    localparam int unsigned    AW       = 10;
    localparam int unsigned    DEPTH    = 4;
    localparam logic [AW-1:0]  RST_ADDR = 10'h000;

    logic          clk = 1'b0;
    logic          rstn;
    logic          flush_i;
    logic [AW-1:0] flush_addr_i;
    logic          instr_valid_o;
    logic [DW-1:0] instr_o;
    logic [AW-1:0] instr_addr_o;
    logic          instr_ready_i;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;

    always #5 clk = ~clk;

    rv_prefetch_buf #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .RESET_ADDR (RST_ADDR)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .flush_i       (flush_i),
        .flush_addr_i  (flush_addr_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_addr_o  (instr_addr_o),
        .instr_ready_i (instr_ready_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    typedef struct {logic [AW-1:0] addr; int due;} pend_t;
    typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} exp_t;

    pend_t pend[$];
    exp_t  exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gnt_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    bit rv_block = 1'b0;
    bit inject = 1'b0;
    int n_grants = 0;
    int first_grant_cyc = -1;
    int n_deliv = 0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'h1000_0000 + DW'(a);
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_stream(input logic [AW-1:0] start);
        logic [AW-1:0] a;
        a = start;
        exp_q.delete();
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back('{addr: a, data: mem_word(a)});
            a = a + AW'(1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drain_clean(input logic [AW-1:0] a);
        step();
        flush_i = 1'b1;
        flush_addr_i = a;
        gnt_pct = 0;
        expect_stream(a);
        n_deliv = 0;
        step();
        flush_i = 1'b0;
        for (int i = 0; i < 30 && pend.size() != 0; i++) step();
        check("drain_idle", pend.size(), 0);
        idle(2);
    endtask

    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory: drives gnt/rvalid a little after the edge, answering grants in order.
    initial begin : mem_drive
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_gnt_i = ($urandom_range(99) < gnt_pct);
            if (inject) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i = 32'hDEAD_BEEF;
            end else if (!rv_block && pend.size() != 0 && pend[0].due <= cyc) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i = mem_word(pend[0].addr);
            end else begin
                mem_rvalid_i = 1'b0;
            end
        end
    end

    initial begin : mem_sample
        forever begin
            @(negedge clk);
            if (mem_rvalid_i && !inject && pend.size() != 0) pend.delete(0);
            if (rstn && mem_req_o && mem_gnt_i) begin
                if (n_grants == 0) first_grant_cyc = cyc;
                n_grants++;
                pend.push_back('{addr: mem_addr_o, due: cyc + int'($urandom_range(lat_max, lat_min))});
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && instr_valid_o && instr_ready_i) begin
                n_deliv++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL deliv_unexpected actual addr=%0h required=none", instr_addr_o);
                end else begin
                    e = exp_q.pop_front();
                    check("deliv_addr", instr_addr_o, e.addr);
                    check("deliv_data", instr_o, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : main
        int vcyc;
        int gaps;
        rstn = 1'b0;
        flush_i = 1'b0;
        flush_addr_i = '0;
        instr_ready_i = 1'b1;
        #3;
        check("rst_valid", instr_valid_o, 0);
        check("rst_req", mem_req_o, 0);
        check("rst_instr", instr_o, 0);
        check("rst_instr_addr", instr_addr_o, RST_ADDR);
        check("rst_mem_addr", mem_addr_o, RST_ADDR);

        // Streaming at latency 1 with the core always ready.
        expect_stream(RST_ADDR);
        idle(3);
        rstn = 1'b1;
        for (int i = 0; i < 20 && n_grants == 0; i++) step();
        check("t1_grant_seen", longint'(n_grants != 0), 1);
        vcyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_valid_o) begin
                vcyc = cyc;
                break;
            end
        end
        check("t1_valid_latency", vcyc - first_grant_cyc, 2);
        gaps = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!instr_valid_o) gaps++;
        end
        check("t1_no_gaps", gaps, 0);
        check("t1_delivered", longint'(n_deliv >= 30), 1);

        // Back-pressure: credits stop requests at DEPTH buffered words.
        step();
        flush_i = 1'b1;
        flush_addr_i = 10'h100;
        instr_ready_i = 1'b0;
        expect_stream(10'h100);
        n_grants = 0;
        n_deliv = 0;
        step();
        flush_i = 1'b0;
        idle(9);
        @(negedge clk);
        check("t2_grants", n_grants, DEPTH);
        check("t2_req_low_full", mem_req_o, 0);
        check("t2_valid_full", instr_valid_o, 1);
        check("t2_no_pop", n_deliv, 0);
        step();
        instr_ready_i = 1'b1;
        @(negedge clk);
        check("t2_req_low_first_pop", mem_req_o, 0);
        @(negedge clk);
        check("t2_req_reassert", mem_req_o, 1);
        idle(20);
        check("t2_delivered", longint'(n_deliv >= 15), 1);

        // Flush with three stale requests in flight (latency 3).
        lat_min = 3;
        lat_max = 3;
        drain_clean(10'h200);
        step();
        gnt_pct = 100;
        idle(2);
        step();
        gnt_pct = 0;
        rv_block = 1'b1;
        flush_i = 1'b1;
        flush_addr_i = 10'h040;
        expect_stream(10'h040);
        n_deliv = 0;
        @(negedge clk);
        check("t3_outstanding", pend.size(), 3);
        check("t3_valid_in_flush", instr_valid_o, 0);
        step();
        flush_i = 1'b0;
        rv_block = 1'b0;
        gnt_pct = 100;
        @(negedge clk);
        check("t3_fifo_cleared", instr_valid_o, 0);
        idle(20);
        check("t3_delivered", longint'(n_deliv >= 10), 1);

        // Flush coinciding with a response, two outstanding.
        lat_min = 2;
        lat_max = 2;
        drain_clean(10'h300);
        step();
        gnt_pct = 100;
        step();
        step();
        gnt_pct = 0;
        flush_i = 1'b1;
        flush_addr_i = 10'h0A0;
        expect_stream(10'h0A0);
        n_deliv = 0;
        @(negedge clk);
        check("t4_rvalid_with_flush", mem_rvalid_i, 1);
        step();
        flush_i = 1'b0;
        gnt_pct = 100;
        idle(20);
        check("t4_delivered", longint'(n_deliv >= 10), 1);

        // Address wrap at the top of the word space.
        lat_min = 1;
        lat_max = 1;
        step();
        flush_i = 1'b1;
        flush_addr_i = 10'h3FE;
        expect_stream(10'h3FE);
        n_deliv = 0;
        step();
        flush_i = 1'b0;
        idle(15);
        check("t5_delivered", longint'(n_deliv >= 8), 1);

        // Random grants, latency, back-pressure and redirects.
        n_deliv = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            lat_min = 1;
            lat_max = 3;
            gnt_pct = 70;
            instr_ready_i = ($urandom_range(3) != 0);
            if ($urandom_range(24) == 0) begin
                flush_i = 1'b1;
                flush_addr_i = AW'($urandom);
                expect_stream(flush_addr_i);
            end else begin
                flush_i = 1'b0;
            end
        end
        step();
        flush_i = 1'b0;
        instr_ready_i = 1'b1;
        check("rand_delivered", longint'(n_deliv >= 100), 1);

        // Asynchronous reset with words buffered and requests in flight.
        lat_min = 3;
        lat_max = 3;
        drain_clean(10'h080);
        step();
        instr_ready_i = 1'b0;
        gnt_pct = 100;
        idle(5);
        @(negedge clk);
        check("t6_buffered_valid", instr_valid_o, 1);
        #2;
        rstn = 1'b0;
        pend.delete();
        gnt_pct = 0;
        #1;
        check("t6_rst_valid", instr_valid_o, 0);
        check("t6_rst_req", mem_req_o, 0);
        check("t6_rst_instr", instr_o, 0);
        check("t6_rst_instr_addr", instr_addr_o, RST_ADDR);
        check("t6_rst_mem_addr", mem_addr_o, RST_ADDR);
        expect_stream(RST_ADDR);
        n_deliv = 0;
        idle(2);
        rstn = 1'b1;
        @(negedge clk);
        check("t6_mem_addr_release", mem_addr_o, RST_ADDR);
        step();
        inject = 1'b1;
        instr_ready_i = 1'b1;
        step();
        inject = 1'b0;
        lat_min = 1;
        lat_max = 1;
        gnt_pct = 100;
        idle(15);
        check("t6_delivered", longint'(n_deliv >= 8), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
